// File: rtl/ca_upsampler_pkg.sv
// Shared ca_upsampler header: code constants, default widths and
// the PRN-to-G2 phase-select tap table.
package ca_upsampler_pkg;

    localparam int DEF_NUM_CHANNELS    = 8;
    localparam int DEF_ACC_WIDTH       = 25;
    localparam int DEF_PHASE_INC_WIDTH = 25;
    localparam int DEF_HIST_WIDTH      = 2;

    localparam int PRN_W  = 5;
    localparam int SLEW_W = 11;
    localparam int CHIP_W = 10;

    // Nominal chip rate: one chip every four samples at zero Doppler.
    localparam int unsigned CA_RATE_INC = 32'd8388608;

    localparam logic [CHIP_W-1:0] MAX_CODE_SHIFT = 10'd1022;

    // {tap_a, tap_b} G2 stages per PRN 1..32; PRN 32 is encoded as 0.
    localparam logic [7:0] G2_TAPS [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

    function automatic logic [7:0] g2_taps(input logic [PRN_W-1:0] prn);
        logic [PRN_W-1:0] idx;
        idx = prn - 5'd1;
        return G2_TAPS[idx];
    endfunction

endpackage

// File: rtl/ca_generator_sw.sv
// Stateless single-chip GPS C/A step: emits the chip of the given
// G1/G2 state and the state one chip later.
module ca_generator_sw
    import ca_upsampler_pkg::*;
(
    input  logic [10:1]      g1,
    input  logic [10:1]      g2,
    input  logic [PRN_W-1:0] prn,
    output logic [10:1]      g1_next,
    output logic [10:1]      g2_next,
    output logic             chip
);

    logic [7:0] taps;
    logic [3:0] sel_a;
    logic [3:0] sel_b;

    always_comb begin
        taps    = g2_taps(prn);
        sel_a   = taps[7:4];
        sel_b   = taps[3:0];
        chip    = g1[10] ^ g2[sel_a] ^ g2[sel_b];
        g1_next = {g1[9:1], g1[3] ^ g1[10]};
        g2_next = {g2[9:1],
                   g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
    end

endmodule

// File: rtl/ca_upsampler_mc.sv
// Multi-channel C/A code upsampler: per-channel code NCO, slew and
// early/prompt/late history, two-cycle fixed-latency pipeline.
module ca_upsampler_mc
    import ca_upsampler_pkg::*;
#(
    parameter int NUM_CHANNELS       = DEF_NUM_CHANNELS,
    parameter int CA_ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int CA_PHASE_INC_WIDTH = DEF_PHASE_INC_WIDTH,
    parameter int CHIP_HIST_WIDTH    = DEF_HIST_WIDTH,
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [CH_W-1:0]               in_chan,
    input  logic [PRN_W-1:0]              in_prn,
    input  logic [CA_PHASE_INC_WIDTH-1:0] in_dphi,
    input  logic                          init_req,
    input  logic [CH_W-1:0]               init_chan,
    input  logic                          slew_req,
    input  logic [CH_W-1:0]               slew_chan,
    input  logic [SLEW_W-1:0]             slew_chips,
    output logic                          out_valid,
    output logic [CH_W-1:0]               out_chan,
    output logic                          out_early,
    output logic                          out_prompt,
    output logic                          out_late,
    output logic                          out_ca_clk,
    output logic                          out_epoch
);

    localparam int AW    = CA_ACC_WIDTH;
    localparam int HW    = CHIP_HIST_WIDTH;
    localparam int MW    = (AW > CA_PHASE_INC_WIDTH) ? AW : CA_PHASE_INC_WIDTH;
    localparam int SUM_W = MW + 2;
    localparam logic [AW-1:0] RATE = AW'(CA_RATE_INC);
    localparam logic [CH_W:0] NCH  = (CH_W + 1)'(NUM_CHANNELS);

    logic [AW-1:0]     acc_q   [NUM_CHANNELS];
    logic [10:1]       g1_q    [NUM_CHANNELS];
    logic [10:1]       g2_q    [NUM_CHANNELS];
    logic [CHIP_W-1:0] chip_q  [NUM_CHANNELS];
    logic [HW-1:0]     ph_q    [NUM_CHANNELS];
    logic [HW-1:0]     lh_q    [NUM_CHANNELS];
    logic [SLEW_W-1:0] slew_q  [NUM_CHANNELS];
    logic              early_q [NUM_CHANNELS];

    logic                          s1_valid;
    logic [CH_W-1:0]               s1_chan;
    logic [PRN_W-1:0]              s1_prn;
    logic [CA_PHASE_INC_WIDTH-1:0] s1_dphi;

    logic              in_ok;
    logic              in_drop;
    logic [SUM_W-1:0]  sum;
    logic              tick;
    logic              advance;
    logic              held;
    logic              epoch;
    logic              early_n;
    logic [AW-1:0]     acc_n;
    logic [10:1]       g1_n;
    logic [10:1]       g2_n;
    logic [CHIP_W-1:0] chip_n;
    logic [SLEW_W-1:0] slew_n;
    logic [HW-1:0]     ph_n;
    logic [HW-1:0]     lh_n;
    logic [10:1]       gen_g1;
    logic [10:1]       gen_g2;
    logic              gen_chip;

    assign in_ok   = in_valid && ({1'b0, in_chan} < NCH);
    assign in_drop = init_req && (init_chan == in_chan);

    ca_generator_sw u_gen (
        .g1      (g1_q[s1_chan]),
        .g2      (g2_q[s1_chan]),
        .prn     (s1_prn),
        .g1_next (gen_g1),
        .g2_next (gen_g2),
        .chip    (gen_chip)
    );

    // State is written back on the same edge that registers the result,
    // so a request one cycle behind already reads the updated channel.
    always_comb begin
        sum     = SUM_W'(acc_q[s1_chan]) + SUM_W'(RATE) + SUM_W'(s1_dphi);
        tick    = |sum[SUM_W-1:AW];
        acc_n   = sum[AW-1:0];
        advance = tick && (slew_q[s1_chan] == '0);
        held    = tick && (slew_q[s1_chan] != '0);
        epoch   = advance && (chip_q[s1_chan] == MAX_CODE_SHIFT);
        g1_n    = advance ? gen_g1 : g1_q[s1_chan];
        g2_n    = advance ? gen_g2 : g2_q[s1_chan];
        early_n = advance ? gen_chip : early_q[s1_chan];
        chip_n  = chip_q[s1_chan];
        if (advance)
            chip_n = epoch ? '0 : chip_q[s1_chan] + 1'b1;
        slew_n  = held ? slew_q[s1_chan] - 1'b1 : slew_q[s1_chan];
        ph_n    = (ph_q[s1_chan] << 1) | HW'(early_n);
        lh_n    = (lh_q[s1_chan] << 1) | HW'(ph_q[s1_chan][HW-1]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_chan    <= '0;
            s1_prn     <= '0;
            s1_dphi    <= '0;
            out_valid  <= 1'b0;
            out_chan   <= '0;
            out_early  <= 1'b0;
            out_prompt <= 1'b0;
            out_late   <= 1'b0;
            out_ca_clk <= 1'b0;
            out_epoch  <= 1'b0;
        end else begin
            s1_valid   <= in_ok && !in_drop;
            s1_chan    <= in_chan;
            s1_prn     <= in_prn;
            s1_dphi    <= in_dphi;
            out_valid  <= s1_valid;
            out_chan   <= s1_valid ? s1_chan : '0;
            out_early  <= s1_valid && early_n;
            out_prompt <= s1_valid && ph_q[s1_chan][HW-1];
            out_late   <= s1_valid && lh_q[s1_chan][HW-1];
            out_ca_clk <= s1_valid && tick;
            out_epoch  <= s1_valid && epoch;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (!reset || (init_req && init_chan == CH_W'(i))) begin
                acc_q[i]   <= '0;
                g1_q[i]    <= 10'h3FF;
                g2_q[i]    <= 10'h3FF;
                chip_q[i]  <= '0;
                ph_q[i]    <= '0;
                lh_q[i]    <= '0;
                slew_q[i]  <= '0;
                early_q[i] <= 1'b0;
            end else begin
                if (s1_valid && s1_chan == CH_W'(i)) begin
                    acc_q[i]   <= acc_n;
                    g1_q[i]    <= g1_n;
                    g2_q[i]    <= g2_n;
                    chip_q[i]  <= chip_n;
                    ph_q[i]    <= ph_n;
                    lh_q[i]    <= lh_n;
                    slew_q[i]  <= slew_n;
                    early_q[i] <= early_n;
                end
                if (slew_req && slew_chan == CH_W'(i))
                    slew_q[i] <= slew_chips;
            end
        end
    end

endmodule

// File: tb/tb_ca_upsampler_mc.sv
// Directed + randomized bench for ca_upsampler_mc against a
// chip-count / code-table reference model.
module tb_ca_upsampler_mc;

    localparam int     NCH  = 8;
    localparam longint MODV = 64'd1 << 25;
    localparam longint RATE = 64'd1 << 23;
    localparam int     FAST = 25165824;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [2:0]  in_chan;
    logic [4:0]  in_prn;
    logic [24:0] in_dphi;
    logic        init_req;
    logic [2:0]  init_chan;
    logic        slew_req;
    logic [2:0]  slew_chan;
    logic [10:0] slew_chips;
    logic        out_valid;
    logic [2:0]  out_chan;
    logic        out_early;
    logic        out_prompt;
    logic        out_late;
    logic        out_ca_clk;
    logic        out_epoch;

    always #5 clk = ~clk;

    ca_upsampler_mc dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_chan    (in_chan),
        .in_prn     (in_prn),
        .in_dphi    (in_dphi),
        .init_req   (init_req),
        .init_chan  (init_chan),
        .slew_req   (slew_req),
        .slew_chan  (slew_chan),
        .slew_chips (slew_chips),
        .out_valid  (out_valid),
        .out_chan   (out_chan),
        .out_early  (out_early),
        .out_prompt (out_prompt),
        .out_late   (out_late),
        .out_ca_clk (out_ca_clk),
        .out_epoch  (out_epoch)
    );

    int checks   = 0;
    int failures = 0;
    string tag   = "reset";

    int tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,
                       1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,
                       4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
    bit code_tab [1:32][0:1022];

    longint m_acc   [NCH];
    int     m_k     [NCH];
    int     m_slew  [NCH];
    bit     m_early [NCH];
    bit     m_hist  [NCH][$];

    logic [8:0] exp_cur;
    logic [8:0] exp_d1;
    logic [8:0] got;

    bit ob_e  [NCH][$];
    bit ob_tk [NCH][$];
    int ob_ep [NCH][$];
    int ob_n  [NCH];

    task automatic build_codes();
        bit g1 [1:10];
        bit g2 [1:10];
        bit f1;
        bit f2;
        for (int p = 1; p <= 32; p++) begin
            for (int j = 1; j <= 10; j++) begin
                g1[j] = 1'b1;
                g2[j] = 1'b1;
            end
            for (int k = 0; k < 1023; k++) begin
                code_tab[p][k] = g1[10] ^ g2[tap_a[p-1]] ^ g2[tap_b[p-1]];
                f1 = g1[3] ^ g1[10];
                f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
                for (int j = 10; j > 1; j--) begin
                    g1[j] = g1[j-1];
                    g2[j] = g2[j-1];
                end
                g1[1] = f1;
                g2[1] = f2;
            end
        end
    endtask

    task automatic m_init(input int c);
        m_acc[c]   = 0;
        m_k[c]     = 0;
        m_slew[c]  = 0;
        m_early[c] = 1'b0;
        m_hist[c].delete();
    endtask

    // One accepted sample: count whole chips emitted, look the chip up.
    task automatic m_sample(input int c, input int prn, input int dphi,
                            output logic [8:0] e);
        longint s;
        bit tk;
        bit ep;
        bit pr;
        bit lt;
        int n;
        s  = m_acc[c] + RATE + longint'(dphi);
        tk = (s >= MODV);
        m_acc[c] = s % MODV;
        ep = 1'b0;
        if (tk) begin
            if (m_slew[c] > 0) begin
                m_slew[c]--;
            end else begin
                m_early[c] = code_tab[prn][m_k[c] % 1023];
                ep = ((m_k[c] % 1023) == 1022);
                m_k[c]++;
            end
        end
        n  = m_hist[c].size();
        pr = (n >= 2) ? m_hist[c][n-2] : 1'b0;
        lt = (n >= 4) ? m_hist[c][n-4] : 1'b0;
        m_hist[c].push_back(m_early[c]);
        if (m_hist[c].size() > 6)
            void'(m_hist[c].pop_front());
        e = {1'b1, 3'(c), m_early[c], pr, lt, tk, ep};
    endtask

    task automatic clear_logs();
        for (int i = 0; i < NCH; i++) begin
            ob_e[i].delete();
            ob_tk[i].delete();
            ob_ep[i].delete();
            ob_n[i] = 0;
        end
    endtask

    task automatic step(input bit v, input int c, input int prn, input int dphi,
                        input bit ini, input int ic,
                        input bit sl, input int sc, input int schips,
                        input bit rst_n);
        int oc;
        in_valid   = v;
        in_chan    = 3'(c);
        in_prn     = 5'(prn);
        in_dphi    = 25'(dphi);
        init_req   = ini;
        init_chan  = 3'(ic);
        slew_req   = sl;
        slew_chan  = 3'(sc);
        slew_chips = 11'(schips);
        reset      = rst_n;
        exp_cur    = '0;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++)
                m_init(i);
            exp_d1 = '0;
        end else begin
            if (sl)
                m_slew[sc] = schips;
            if (ini)
                m_init(ic);
            if (v && !(ini && ic == c))
                m_sample(c, prn, dphi, exp_cur);
        end
        @(posedge clk);
        #1;
        got = {out_valid, out_chan, out_early, out_prompt,
               out_late, out_ca_clk, out_epoch};
        checks++;
        assert (got === exp_d1) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp_d1);
        end
        if (!$isunknown(got) && got[8]) begin
            oc = int'(got[7:5]);
            ob_e[oc].push_back(got[4]);
            if (got[1])
                ob_tk[oc].push_back(got[4]);
            if (got[0])
                ob_ep[oc].push_back(ob_n[oc]);
            ob_n[oc]++;
        end
        exp_d1 = exp_cur;
    endtask

    task automatic req(input int c, input int prn, input int dphi);
        step(1'b1, c, prn, dphi, 1'b0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic init_ch(input int c);
        step(1'b0, 0, 0, 0, 1'b1, c, 1'b0, 0, 0, 1'b1);
    endtask

    task automatic slew_ch(input int c, input int n);
        step(1'b0, 0, 0, 0, 1'b0, 0, 1'b1, c, n, 1'b1);
    endtask

    task automatic chk(input string t, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", t, obs, expv);
        end
    endtask

    initial begin
        logic [9:0] pat;
        int d0;
        int d1;
        int dt;
        int r;
        int n;

        build_codes();
        exp_d1 = '0;
        clear_logs();

        tag = "reset";
        step(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0);

        tag = "prn1_seq";
        for (int i = 0; i < 10; i++)
            req(0, 1, FAST);
        idle();
        idle();
        pat = 10'b1100100000;
        chk("prn1_count", ob_e[0].size(), 10);
        n = (ob_e[0].size() < 10) ? ob_e[0].size() : 10;
        for (int k = 0; k < n; k++)
            chk("prn1_chip", int'(ob_e[0][k]), int'(pat[9-k]));

        tag = "epl_slow";
        init_ch(0);
        for (int i = 0; i < 40; i++)
            req(0, 5, 0);
        idle();
        idle();

        tag = "interleave";
        init_ch(0);
        init_ch(1);
        d0 = int'($urandom_range(0, 1 << 24));
        d1 = int'($urandom_range(1 << 23, (1 << 25) - 1));
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)
                req(0, 7, d0);
            else if (r < 8)
                req(1, 32, d1);
            else if (r == 8)
                idle();
            else
                step(1'b1, 0, 7, d0, 1'b0, 0, 1'b1, 1,
                     int'($urandom_range(0, 5)), 1'b1);
        end
        idle();
        idle();

        tag = "slew_twin";
        init_ch(2);
        init_ch(3);
        slew_ch(2, 3);
        clear_logs();
        dt = FAST - int'($urandom_range(0, 1 << 21));
        for (int i = 0; i < 40; i++) begin
            req(2, 9, dt);
            req(3, 9, dt);
        end
        idle();
        idle();
        chk("twin_ticks", int'(ob_tk[2].size() >= 13 && ob_tk[3].size() >= 10), 1);
        if (ob_tk[2].size() >= 13 && ob_tk[3].size() >= 10) begin
            for (int i = 0; i < 3; i++)
                chk("slew_hold", int'(ob_tk[2][i]), 0);
            for (int i = 0; i < 10; i++) begin
                chk("slew_late", int'(ob_tk[2][i+3]), int'(code_tab[9][i]));
                chk("twin_ref", int'(ob_tk[3][i]), int'(code_tab[9][i]));
            end
        end

        tag = "init_slew_same";
        step(1'b0, 0, 0, 0, 1'b1, 4, 1'b1, 4, 5, 1'b1);
        for (int i = 0; i < 6; i++)
            req(4, 11, FAST);
        tag = "slew_overwrite";
        init_ch(5);
        slew_ch(5, 7);
        slew_ch(5, 2);
        for (int i = 0; i < 8; i++)
            req(5, 12, FAST);
        idle();
        idle();

        tag = "epoch";
        init_ch(0);
        clear_logs();
        for (int i = 0; i < 2050; i++)
            req(0, 3, FAST);
        idle();
        idle();
        chk("epoch_count", ob_ep[0].size(), 2);
        if (ob_ep[0].size() == 2) begin
            chk("epoch_first", ob_ep[0][0], 1022);
            chk("epoch_second", ob_ep[0][1], 2045);
        end

        tag = "init_drop";
        for (int i = 0; i < 3; i++)
            req(0, 1, FAST);
        step(1'b1, 0, 1, FAST, 1'b1, 0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++)
            req(0, 1, FAST);
        tag = "mid_reset";
        step(1'b1, 0, 1, FAST, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        tag = "post_reset";
        for (int i = 0; i < 4; i++)
            req(0, 1, FAST);
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
